// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and default width for the serial adder
package serial_adder_pkg;

    localparam int SA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sa_state_t;

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - combinational one-bit full adder cell
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ c;
    assign co = (x & y) | (x & c) | (y & c);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder around one fa_cell, LSB first; SERIAL_ADDER_OVF_EN adds a signed overflow flag
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    sa_state_t        state;
    sa_state_t        state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             cell_s;
    logic             cell_co;
    logic             last_bit;
    logic             accept;

    fa_cell u_fa (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .c  (carry),
        .s  (cell_s),
        .co (cell_co)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = start ? ST_SHIFT : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // sum_sr is left untouched on capture so the previous result stays readable until shifting begins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == ST_SHIFT) begin
            sum_sr <= {cell_s, sum_sr[WIDTH-1:1]};
            carry  <= cell_co;
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            cnt    <= cnt + CNT_W'(1);
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // On the MSB cycle, carry is the carry into the MSB and cell_co the carry out of it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if ((state == ST_SHIFT) && last_bit) begin
            ovf <= carry ^ cell_co;
        end
    end
`endif

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);
    assign sum  = sum_sr;
    assign cout = carry;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder stage built around a single one-bit full-adder cell.
- Accepts two WIDTH-bit operands plus carry-in via a start handshake.
- Presents operand bits LSB-first to the cell, one bit per clock, and registers the ripple carry between cycles.
- Collects the sum bits into a result register and signals completion with a done pulse.
- Sits upstream of the full-adder cell, feeding it In1/In2/Cin each cycle and consuming its Sum/Cout.

Parameters:
- WIDTH, 8, operand and sum width in bits (>= 2).
- CNT_W, $clog2(WIDTH+1), width of the bit counter (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- cin  input  1  carry-in, captured on accepted start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse, high in DONE.
- sum  output  WIDTH  result; valid from done until the next accepted start.
- cout  output  1  final carry-out; valid with sum.

Behaviour:
- Reset (async, rst=1):
  - State becomes IDLE.
  - Shift registers, carry flop and counter cleared to 0.
  - busy=0, done=0, sum=0, cout=0.
  - Reset mid-operation aborts immediately; no done is issued.
- States: IDLE, SHIFT, DONE (2-bit encoding, IDLE=0).
- IDLE:
  - start=1 -> a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, go to SHIFT.
  - start=0 -> stay.
- SHIFT, each cycle:
  - Cell inputs are a_sr[0], b_sr[0], carry.
  - Cell equations: s = x^y^c, co = (x&y)|(x&c)|(y&c).
  - Updates: sum_sr <= {s, sum_sr[WIDTH-1:1]}; carry <= co; a_sr and b_sr shift right, filling with 0; cnt <= cnt+1.
  - When cnt==WIDTH-1, transfer to DONE on the same edge.
- DONE (exactly one cycle):
  - done=1; sum=sum_sr; cout=carry.
  - start=1 -> capture new operands, go to SHIFT (back-to-back operation).
  - start=0 -> go to IDLE.
- sum and cout hold their value in IDLE until the next accepted start.
- Latency: start accepted at edge 0 -> done high in the cycle after edge WIDTH. Throughput is one add per WIDTH+1 cycles.
- start during SHIFT is ignored; a and b may change freely while busy.
- busy and done are registered (Moore) outputs, never high together.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no saturation.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit).
  - Registered at the transition into DONE as the carry into the MSB XOR the carry out of the MSB (two's-complement overflow).
  - Held with sum; reset value 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package serial_adder_pkg holds:
  - the state encoding constants ST_IDLE, ST_SHIFT, ST_DONE;
  - the default width constant SA_WIDTH_DEF=8.
- Sub-module fa_cell: purely combinational one-bit full adder (x, y, c -> s, co). Instantiated once; reusable by other arithmetic stages.

Test Plan:
- Basic add: WIDTH=8, a=0x3C, b=0x0F, cin=0, start pulse -> busy high for 8 cycles, done in cycle 9, sum=0x4B, cout=0.
- Wrap/carry: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; with OVF_EN, ovf=0. Also a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Signed overflow (OVF_EN): a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
- Start while busy: start a=0x10, b=0x20, then pulse start with a=0xAA, b=0x55 at cycle 3 -> result sum=0x30; second request never accepted.
- Back-to-back: start held high continuously, a=0x01, b=0x02 then a=0x04, b=0x04 -> done pulses 9 cycles apart; results 0x03, then 0x08.
- Reset mid-op: assert rst at cycle 4 of SHIFT -> outputs 0 immediately (async), state IDLE, no done. A following start with a=0x05, b=0x06 yields 0x0B.
